// File: rtl/partial_word_unpacker.sv
// rtl/partial_word_unpacker.sv - wide-word to narrow-slice unpacker with word FIFO and status
// Words queue in a small FIFO; a two-state serializer emits RATIO slices per word.
module partial_word_unpacker #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int HIGH_FIRST = 1,
  parameter int DEPTH      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           status
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [IN_WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [IN_WIDTH-1:0]  r_word;
  logic [IDX_W-1:0]     r_slice_idx;

  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_push;
  logic                 w_load;
  logic                 w_out_hs;
  logic                 w_last;
  logic [OUT_WIDTH-1:0] w_slice;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_W'(DEPTH));
  assign in_ready     = enable && !w_fifo_full;
  assign w_push       = in_valid && in_ready;
  assign w_out_hs     = out_valid && out_ready;
  assign w_last       = (r_slice_idx == IDX_W'(RATIO - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; w_load doubles as the FIFO pop
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !w_fifo_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_out_hs && w_last) begin
          if (enable && !w_fifo_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (r_state == ST_SHIFT);
    data_out  = out_valid ? w_slice : '0;
    status    = {out_valid && w_last, w_fifo_full, w_fifo_empty, out_valid};
  end

  always_comb begin
    w_slice = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (r_slice_idx == IDX_W'(k)) begin
        if (HIGH_FIRST != 0) begin
          w_slice = r_word[IN_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH];
        end else begin
          w_slice = r_word[k*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_word      <= '0;
      r_slice_idx <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A load on the final-slice handshake restarts the index with no bubble
      if (w_load) begin
        r_word      <= r_mem[r_rd_ptr];
        r_slice_idx <= '0;
      end else if (w_out_hs && !w_last) begin
        r_slice_idx <= r_slice_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_partial_word_unpacker.sv
// tb/tb_partial_word_unpacker.sv - directed self-checking bench for partial_word_unpacker
module tb_partial_word_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  status;

  logic        q_enable;
  logic [31:0] q_data_in;
  logic        q_in_valid;
  logic        q_in_ready;
  logic [7:0]  q_data_out;
  logic        q_out_valid;
  logic        q_out_ready;
  logic [3:0]  q_status;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] w2 [3] = '{16'h1234, 16'h5678, 16'h9ABC};
  logic [7:0]  b2 [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
  logic [7:0]  b3 [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0]  b6 [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [3:0]  s6 [4] = '{4'b0011, 4'b0011, 4'b0011, 4'b1011};

  always #5 clk = ~clk;

  partial_word_unpacker u_dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .status    (status)
  );

  partial_word_unpacker #(
    .IN_WIDTH   (32),
    .OUT_WIDTH  (8),
    .HIGH_FIRST (0),
    .DEPTH      (2)
  ) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .enable    (q_enable),
    .data_in   (q_data_in),
    .in_valid  (q_in_valid),
    .in_ready  (q_in_ready),
    .data_out  (q_data_out),
    .out_valid (q_out_valid),
    .out_ready (q_out_ready),
    .status    (q_status)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; data_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    q_enable = 1'b0; q_data_in = '0; q_in_valid = 1'b0; q_out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_status", 32'(status), 32'b0010);

    // Single word, high byte first
    reset = 1'b0; enable = 1'b1; out_ready = 1'b1; data_in = 16'hA55A; in_valid = 1'b1;
    #1;
    check("t1_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    #1;
    check("t1_gap_valid", 32'(out_valid), 32'h0);
    check("t1_gap_status", 32'(status), 32'b0000);
    tick();
    check("t1_b0_valid", 32'(out_valid), 32'h1);
    check("t1_b0_data", 32'(data_out), 32'hA5);
    check("t1_b0_status", 32'(status), 32'b0011);
    tick();
    check("t1_b1_data", 32'(data_out), 32'h5A);
    check("t1_b1_status", 32'(status), 32'b1011);
    tick();
    check("t1_idle_valid", 32'(out_valid), 32'h0);
    check("t1_idle_status", 32'(status), 32'b0010);

    // Back-to-back words, no gaps
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        data_in = w2[c]; in_valid = 1'b1;
        #1;
        check("t2_in_ready", 32'(in_ready), 32'h1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 6) begin
        check("t2_valid", 32'(out_valid), 32'h1);
        check("t2_data", 32'(data_out), 32'(b2[c-1]));
      end
    end
    check("t2_idle_valid", 32'(out_valid), 32'h0);

    // Backpressure with a full FIFO
    out_ready = 1'b0;
    data_in = 16'h1122; in_valid = 1'b1; tick();
    data_in = 16'h3344; tick();
    data_in = 16'h5566; tick();
    data_in = 16'h7788;
    #1;
    check("t3_in_ready", 32'(in_ready), 32'h0);
    check("t3_status", 32'(status), 32'b0101);
    check("t3_data", 32'(data_out), 32'h11);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t3_stall_data", 32'(data_out), 32'h11);
      check("t3_stall_status", 32'(status), 32'b0101);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t3_valid", 32'(out_valid), 32'h1);
      check("t3_data_seq", 32'(data_out), 32'(b3[c]));
    end
    tick();
    check("t3_idle_status", 32'(status), 32'b0010);

    // Enable dropped mid-word
    data_in = 16'hA55A; in_valid = 1'b1; tick();
    data_in = 16'hC3E1; tick();
    check("t4_b0_data", 32'(data_out), 32'hA5);
    in_valid = 1'b0; enable = 1'b0;
    #1;
    check("t4_in_ready_off", 32'(in_ready), 32'h0);
    tick();
    check("t4_b1_data", 32'(data_out), 32'h5A);
    check("t4_b1_valid", 32'(out_valid), 32'h1);
    tick();
    check("t4_hold_valid", 32'(out_valid), 32'h0);
    check("t4_hold_status", 32'(status), 32'b0000);
    tick();
    check("t4_hold2_valid", 32'(out_valid), 32'h0);
    enable = 1'b1;
    #1;
    check("t4_in_ready_on", 32'(in_ready), 32'h1);
    tick();
    check("t4_q0_data", 32'(data_out), 32'hC3);
    tick();
    check("t4_q1_data", 32'(data_out), 32'hE1);
    tick();
    check("t4_idle_status", 32'(status), 32'b0010);

    // Reset mid-word discards the word and the queued FIFO entry
    data_in = 16'hA55A; in_valid = 1'b1; tick();
    data_in = 16'h7777; tick();
    in_valid = 1'b0;
    check("t5_b0_data", 32'(data_out), 32'hA5);
    tick();
    check("t5_b1_data", 32'(data_out), 32'h5A);
    reset = 1'b1; enable = 1'b0;
    tick();
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_status", 32'(status), 32'b0010);
    reset = 1'b0; enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_post_valid", 32'(out_valid), 32'h0);
      check("t5_post_status", 32'(status), 32'b0010);
    end

    // 32-bit words, least-significant byte first
    q_enable = 1'b1; q_out_ready = 1'b1; q_data_in = 32'h11223344; q_in_valid = 1'b1;
    #1;
    check("t6_in_ready", 32'(q_in_ready), 32'h1);
    tick();
    q_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_data", 32'(q_data_out), 32'(b6[c]));
      check("t6_status", 32'(q_status), 32'(s6[c]));
    end
    tick();
    check("t6_idle_status", 32'(q_status), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
